// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority vote, false-start rejection, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit check with a parity_err_o pulse.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic [15:0]          frame_count_o
);

    localparam int unsigned Div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW  = $clog2(DATA_BITS);
    localparam int unsigned Mid   = OVERSAMPLE / 2;

    localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] SampA    = TickW'(Mid - 1);
    localparam logic [TickW-1:0] SampB    = TickW'(Mid);
    localparam logic [TickW-1:0] SampC    = TickW'(Mid + 1);
    localparam logic [IdxW-1:0]  DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0]  StopLast = IdxW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e state_q, state_d;

    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DivW-1:0]      div_q, div_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 start_edge, tick, sample_pt, bit_end, maj, stop_last;
    logic                 frame_ok, deliver, accept;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

    assign tick       = (div_q == DivLast);
    assign start_edge = (state_q == StIdle) && rxd_prev_q && !rxd_sync_q;
    assign sample_pt  = tick && (tick_cnt_q == SampC);
    assign bit_end    = tick && (tick_cnt_q == TickLast);
    // Third vote is the live sample taken on the SampC tick.
    assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) |
                        (samp_q[1] & rxd_sync_q);
    assign stop_last  = (bit_idx_q == StopLast);
    assign frame_ok   = (state_q == StStop) && sample_pt && maj && stop_last;
`ifdef UART_RX_PARITY_EN
    assign deliver    = frame_ok && !par_bad_q;
`else
    assign deliver    = frame_ok;
`endif
    assign accept     = rx_valid_q && rx_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_edge) state_d = StStart;
            StStart: begin
                if (sample_pt && maj) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && (bit_idx_q == DataLast)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: if (bit_end) state_d = StStop;
`endif
            // Leave at the last stop sample so a back-to-back start edge is not missed.
            StStop: begin
                if (sample_pt) begin
                    if (!maj) begin
                        state_d = StBreak;
                    end else if (stop_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StBreak: if (rxd_sync_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d      = (start_edge || tick) ? '0 : div_q + DivW'(1);
        tick_cnt_d = tick_cnt_q;
        if (start_edge) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
        end
        samp_d = samp_q;
        if (tick && (tick_cnt_q == SampA)) samp_d[0] = rxd_sync_q;
        if (tick && (tick_cnt_q == SampB)) samp_d[1] = rxd_sync_q;
        shift_d = shift_q;
        if ((state_q == StData) && sample_pt) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q;
        if (bit_end) begin
            if (state_q == StStart) begin
                bit_idx_d = '0;
            end else if (state_q == StData) begin
                bit_idx_d = (bit_idx_q == DataLast) ? '0 : bit_idx_q + IdxW'(1);
            end else if (state_q == StStop) begin
                bit_idx_d = bit_idx_q + IdxW'(1);
            end
        end
        frame_err_d   = (state_q == StStop) && sample_pt && !maj;
        overrun_d     = deliver && rx_valid_q && !rx_ready_i;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_count_d = frame_count_q;
        if (deliver && (!rx_valid_q || rx_ready_i)) begin
            rx_data_d     = shift_q;
            rx_valid_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        if (start_edge) begin
            par_bad_d = 1'b0;
        end else if ((state_q == StParity) && sample_pt) begin
            par_bad_d = (^shift_q ^ maj) != PARITY_ODD;
        end
        parity_err_d = frame_ok && par_bad_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rxd_meta_q    <= 1'b1;
            rxd_sync_q    <= 1'b1;
            rxd_prev_q    <= 1'b1;
            div_q         <= '0;
            tick_cnt_q    <= '0;
            samp_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rxd_meta_q    <= rxd_i;
            rxd_sync_q    <= rxd_meta_q;
            rxd_prev_q    <= rxd_sync_q;
            div_q         <= div_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_q        <= samp_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_busy_o     = (state_q != StIdle);
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_q;
    assign frame_count_o = frame_count_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus random frames against a frame-level model.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ   = 307_200;
    localparam int unsigned BAUD_RATE  = 9600;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned TICK_CLKS  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BIT_CLKS   = TICK_CLKS * OVERSAMPLE;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun_err;
    logic [15:0] frame_count;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rxd_i        (rxd),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .rx_busy_o    (rx_busy),
        .frame_err_o  (frame_err),
        .overrun_err_o(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .frame_count_o(frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pe_cnt   = 0;
    int vcyc_cnt = 0;

    // Frame-level model: what each sent frame should produce.
    logic [7:0]  exp_q[$];
    bit          model_full = 1'b0;
    int          exp_fe = 0;
    int          exp_ov = 0;
    int          exp_pe = 0;
    logic [15:0] exp_count = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok);
        if (!stop_ok) begin
            exp_fe++;
        end else if (!par_ok) begin
            exp_pe++;
        end else if (model_full) begin
            exp_ov++;
        end else begin
            exp_q.push_back(data);
            exp_count = exp_count + 16'd1;
            if (!rx_ready) model_full = 1'b1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #2;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        step(BIT_CLKS);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] data, input logic stop_bit, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
        drive_bit(par);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_frame_p(data, stop_bit, ^data);
    endtask
`else
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_bit);
    endtask
`endif

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (rx_valid) vcyc_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("hs_extra", {24'h0, rx_data}, 32'hdead_beef);
                else check("hs_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, {24'h0, rx_data}, 32'h0);
        check({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
        check({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
        check({tag, "_oerr"}, {31'h0, overrun_err}, 32'h0);
        check({tag, "_count"}, {16'h0, frame_count}, 32'h0);
    endtask

    initial begin
        int vb, fb, ob;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        reset    = 1'b1;
        step(4);
        check_zero_outputs("rst");
        reset = 1'b0;
        step(2 * BIT_CLKS);

        // Single 8N1 frame, consumer always ready.
        vb = vcyc_cnt; fb = fe_cnt; ob = ov_cnt;
        model_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1);
        step(BIT_CLKS);
        check("t1_data", {24'h0, rx_data}, 32'hA5);
        check("t1_vcyc", vcyc_cnt - vb, 1);
        check("t1_count", {16'h0, frame_count}, 32'd1);
        check("t1_errs", (fe_cnt - fb) + (ov_cnt - ob), 0);

        // Short low glitch must be rejected as a false start.
        vb = vcyc_cnt;
        rxd = 1'b0;
        step(3 * TICK_CLKS);
        check("t2_busy_hi", {31'h0, rx_busy}, 32'h1);
        rxd = 1'b1;
        step(BIT_CLKS);
        check("t2_busy_lo", {31'h0, rx_busy}, 32'h0);
        check("t2_vcyc", vcyc_cnt - vb, 0);
        check("t2_count", {16'h0, frame_count}, {16'h0, exp_count});

        // Bad stop bit followed by a held-low line.
        vb = vcyc_cnt; fb = fe_cnt;
        model_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0);
        step(3 * BIT_CLKS);
        check("t3_ferr", fe_cnt - fb, 1);
        check("t3_busy_brk", {31'h0, rx_busy}, 32'h1);
        check("t3_vcyc", vcyc_cnt - vb, 0);
        rxd = 1'b1;
        step(BIT_CLKS);
        check("t3_busy_lo", {31'h0, rx_busy}, 32'h0);
        model_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1);
        step(BIT_CLKS);
        check("t3_data", {24'h0, rx_data}, 32'h55);
        check("t3_vcyc2", vcyc_cnt - vb, 1);

        // Overrun: consumer stalled across two back-to-back frames.
        ob = ov_cnt;
        rx_ready = 1'b0;
        model_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h11, 1'b1);
        model_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1);
        step(BIT_CLKS);
        check("t4_valid", {31'h0, rx_valid}, 32'h1);
        check("t4_data", {24'h0, rx_data}, 32'h11);
        check("t4_oerr", ov_cnt - ob, 1);
        check("t4_count", {16'h0, frame_count}, {16'h0, exp_count});
        rx_ready   = 1'b1;
        model_full = 1'b0;
        step(3);
        check("t4_valid_lo", {31'h0, rx_valid}, 32'h0);

        // Reset during data bit 4 aborts the frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rxd = 1'b1;
        step(BIT_CLKS / 2);
        reset = 1'b1;
        rxd   = 1'b1;
        step(3);
        check_zero_outputs("t5_rst");
        exp_q.delete();
        model_full = 1'b0;
        exp_count  = 16'd0;
        reset = 1'b0;
        step(2 * BIT_CLKS);
        model_frame(8'h0F, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1);
        step(BIT_CLKS);
        check("t5_data", {24'h0, rx_data}, 32'h0F);
        check("t5_count", {16'h0, frame_count}, 32'd1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity rejected, correct parity accepted.
        vb = vcyc_cnt;
        model_frame(8'h07, 1'b1, 1'b0);
        send_frame_p(8'h07, 1'b1, 1'b0);
        step(BIT_CLKS);
        check("t6_perr", pe_cnt, exp_pe);
        check("t6_vcyc", vcyc_cnt - vb, 0);
        model_frame(8'h07, 1'b1, 1'b1);
        send_frame_p(8'h07, 1'b1, 1'b1);
        step(BIT_CLKS);
        check("t6_data", {24'h0, rx_data}, 32'h07);
`endif

        // Random frames with occasional bad stop bits and random idle gaps.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         bad;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            gap = bad ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 40));
            model_frame(d, !bad, 1'b1);
            send_frame(d, !bad);
            rxd = 1'b1;
            step(gap);
        end
        step(2 * BIT_CLKS);

        check("end_queue", exp_q.size(), 0);
        check("end_ferr", fe_cnt, exp_fe);
        check("end_oerr", ov_cnt, exp_ov);
        check("end_perr", pe_cnt, exp_pe);
        check("end_count", {16'h0, frame_count}, {16'h0, exp_count});
        check("end_busy", {31'h0, rx_busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
